// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester and memory-side signals of mem_port_arbiter.
// Handshake: a requester raises x_req with stable address/data and holds it
// until it sees the one-cycle x_ack pulse; memory side gets a one-cycle mem_en
// strobe and answers with mem_ready (with mem_rdata) one or more cycles later.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic [3:0]        d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic [31:0]       d_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic              busy;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    // Requester / memory side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port 32-bit memory between instruction fetch and data
// load/store. Data wins arbitration unless fetch has been passed over
// STARVE_LIMIT times in a row while pending. All outputs are registered.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus,
    output logic [2:0]        dbg_state,
    output logic [3:0]        dbg_starve_cnt
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_IF = 3'd1,
        ISSUE_D  = 3'd2,
        WAIT_IF  = 3'd3,
        WAIT_D   = 3'd4
    } state_t;

    localparam logic [3:0]        LIMIT     = STARVE_LIMIT[3:0];
    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;

    state_t     state;
    logic [3:0] starve_cnt;
    logic       grant_d;

    // Data takes the port unless fetch is waiting and has hit the starvation limit.
    assign grant_d = bus.d_req && (!bus.if_req || (starve_cnt < LIMIT));

    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

    // Access sequencer: arbitrate in IDLE, strobe in ISSUE, wait for mem_ready in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            starve_cnt    <= 4'd0;
            bus.if_ack    <= 1'b0;
            bus.d_ack     <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 4'b0000;
            bus.mem_addr  <= ADDR_ZERO;
            bus.mem_wdata <= 32'd0;
            bus.if_rdata  <= 32'd0;
            bus.d_rdata   <= 32'd0;
            bus.busy      <= 1'b0;
        end else begin
            bus.if_ack <= 1'b0;
            bus.d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state         <= ISSUE_D;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= bus.d_we;
                        bus.mem_addr  <= bus.d_addr;
                        bus.mem_wdata <= bus.d_wdata;
                        bus.busy      <= 1'b1;
                        // Count only grants that bypass a waiting fetch; saturate at the limit.
                        if (bus.if_req && (starve_cnt < LIMIT)) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end else if (bus.if_req) begin
                        state         <= ISSUE_IF;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= 4'b0000;
                        bus.mem_addr  <= bus.if_addr;
                        bus.mem_wdata <= 32'd0;
                        bus.busy      <= 1'b1;
                        starve_cnt    <= 4'd0;
                    end
                end
                ISSUE_IF: begin
                    state      <= WAIT_IF;
                    bus.mem_en <= 1'b0;
                end
                ISSUE_D: begin
                    state      <= WAIT_D;
                    bus.mem_en <= 1'b0;
                end
                WAIT_IF: begin
                    if (bus.mem_ready) begin
                        state        <= IDLE;
                        bus.if_rdata <= bus.mem_rdata;
                        bus.if_ack   <= 1'b1;
                        bus.busy     <= 1'b0;
                    end
                end
                WAIT_D: begin
                    if (bus.mem_ready) begin
                        state       <= IDLE;
                        bus.d_rdata <= bus.mem_rdata;
                        bus.d_ack   <= 1'b1;
                        bus.busy    <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus.mem_en <= 1'b0;
                    bus.busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: bench acts as both requesters and the memory.
// A transaction-level model tracks which request should be granted, what the
// memory returns, and when acks and read data must appear.
module tb_mem_port_arbiter;
    localparam int ADDR_W       = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int W            = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dbg_state;
    logic [3:0] dbg_starve_cnt;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .dbg_state      (dbg_state),
        .dbg_starve_cnt (dbg_starve_cnt)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Memory contents, word-indexed by address bits [7:2]
    logic [31:0] mem_words [0:63];

    // Scoreboard and model state
    logic [W-1:0] exp_q[$];
    int  grant_q[$];
    int  grant_cyc_q[$];
    bit  inflight, grant_is_d, pending, resp_done;
    int  wait_cnt, data_run, mem_lat;
    bit  rand_lat, spurious_en, scramble_en, keep_if, keep_d;
    logic [ADDR_W-1:0] req_if_addr, req_d_addr, lat_addr;
    logic [3:0]        req_d_we, lat_we;
    logic [31:0]       req_d_wdata, lat_wdata, rsp_word;
    logic [31:0]       last_if_rdata, last_d_rdata;
    int  if_ack_cyc, d_ack_cyc, if_ack_cnt, d_ack_cnt;

    function automatic logic [ADDR_W-1:0] rand_addr();
        return ADDR_W'({$urandom} & 32'hFFFF_FFFC);
    endfunction

    // Driver tasks
    task automatic raise_if(input logic [ADDR_W-1:0] a);
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        req_if_addr = a;
    endtask

    task automatic raise_d(input logic [3:0] we, input logic [ADDR_W-1:0] a, input logic [31:0] wd);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        req_d_we    = we;
        req_d_addr  = a;
        req_d_wdata = wd;
    endtask

    task automatic raise_d_rand();
        logic [3:0] we;
        we = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
        raise_d(we, rand_addr(), $urandom);
    endtask

    // One clock: sample #1 after the edge, score it, then play memory and requesters.
    task automatic cycle();
        bit p_if, p_d, p_rst, exp_en, exp_if_ack, exp_d_ack, want_d;
        int idx;
        @(posedge clk);
        #1;
        cyc++;
        p_if  = bus.if_req;
        p_d   = bus.d_req;
        p_rst = rst;
        if (p_rst) begin
            total++;
            if ({bus.busy, bus.mem_en, bus.if_ack, bus.d_ack} !== 4'b0000 || bus.mem_we !== 4'b0000 ||
                bus.mem_addr !== '0 || bus.mem_wdata !== 32'd0 || bus.if_rdata !== 32'd0 ||
                bus.d_rdata !== 32'd0 || dbg_starve_cnt !== 4'd0) begin
                bad++;
                $display("FAIL reset_values cyc=%0d busy=%b en=%b ack=%b%b we=%h addr=%h wd=%h ir=%h dr=%h cnt=%0d required all zero",
                         cyc, bus.busy, bus.mem_en, bus.if_ack, bus.d_ack, bus.mem_we, bus.mem_addr,
                         bus.mem_wdata, bus.if_rdata, bus.d_rdata, dbg_starve_cnt);
            end
            inflight = 0; pending = 0; resp_done = 0; data_run = 0;
            exp_q.delete();
            last_if_rdata = 32'd0; last_d_rdata = 32'd0;
            bus.mem_ready = 1'b0;
            return;
        end

        exp_en     = !inflight && (p_if || p_d);
        exp_if_ack = resp_done && !grant_is_d;
        exp_d_ack  = resp_done && grant_is_d;
        total++;
        if (bus.mem_en !== exp_en) begin
            bad++;
            $display("FAIL mem_en cyc=%0d got=%b exp=%b", cyc, bus.mem_en, exp_en);
        end
        total++;
        if (bus.if_ack !== exp_if_ack) begin
            bad++;
            $display("FAIL if_ack cyc=%0d got=%b exp=%b", cyc, bus.if_ack, exp_if_ack);
        end
        total++;
        if (bus.d_ack !== exp_d_ack) begin
            bad++;
            $display("FAIL d_ack cyc=%0d got=%b exp=%b", cyc, bus.d_ack, exp_d_ack);
        end

        // Completion seen by the requester
        if (resp_done) begin
            if (grant_is_d) last_d_rdata = exp_q.pop_front();
            else last_if_rdata = exp_q.pop_front();
            total++;
            if (bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL busy_ack cyc=%0d got=%b exp=0", cyc, bus.busy);
            end
            inflight  = 0;
            resp_done = 0;
            if (grant_is_d) begin
                d_ack_cyc = cyc; d_ack_cnt++;
                if (keep_d) raise_d_rand(); else bus.d_req = 1'b0;
            end else begin
                if_ack_cyc = cyc; if_ack_cnt++;
                if (keep_if) raise_if(rand_addr()); else bus.if_req = 1'b0;
            end
        end
        total++;
        if (bus.if_rdata !== last_if_rdata) begin
            bad++;
            $display("FAIL if_rdata cyc=%0d got=%h exp=%h", cyc, bus.if_rdata, last_if_rdata);
        end
        total++;
        if (bus.d_rdata !== last_d_rdata) begin
            bad++;
            $display("FAIL d_rdata cyc=%0d got=%h exp=%h", cyc, bus.d_rdata, last_d_rdata);
        end

        // Memory: an access in its wait phase
        if (pending) begin
            total++;
            if (bus.mem_en !== 1'b0 || bus.busy !== 1'b1 || bus.mem_addr !== lat_addr ||
                bus.mem_we !== lat_we || (grant_is_d && bus.mem_wdata !== lat_wdata)) begin
                bad++;
                $display("FAIL wait_hold cyc=%0d en=%b busy=%b addr=%h we=%h wd=%h exp addr=%h we=%h wd=%h",
                         cyc, bus.mem_en, bus.busy, bus.mem_addr, bus.mem_we, bus.mem_wdata,
                         lat_addr, lat_we, lat_wdata);
            end
            if (wait_cnt == 0) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = rsp_word;
                pending   = 0;
                resp_done = 1;
            end else begin
                wait_cnt--;
                bus.mem_ready = 1'b0;
                bus.mem_rdata = $urandom;
            end
        end else begin
            bus.mem_ready = spurious_en ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mem_rdata = $urandom;
        end

        // New grant expected this cycle
        if (exp_en) begin
            want_d    = p_d && (!p_if || data_run < STARVE_LIMIT);
            lat_addr  = want_d ? req_d_addr : req_if_addr;
            lat_we    = want_d ? req_d_we : 4'b0000;
            lat_wdata = req_d_wdata;
            total++;
            if (bus.busy !== 1'b1 || bus.mem_addr !== lat_addr || bus.mem_we !== lat_we) begin
                bad++;
                $display("FAIL issue cyc=%0d who_d=%0b busy=%b addr=%h we=%h exp addr=%h we=%h",
                         cyc, want_d, bus.busy, bus.mem_addr, bus.mem_we, lat_addr, lat_we);
            end
            if (want_d) begin
                total++;
                if (bus.mem_wdata !== lat_wdata) begin
                    bad++;
                    $display("FAIL issue_wdata cyc=%0d got=%h exp=%h", cyc, bus.mem_wdata, lat_wdata);
                end
                if (p_if && data_run < STARVE_LIMIT) data_run++;
            end else begin
                data_run = 0;
            end
            grant_is_d = want_d;
            grant_q.push_back(want_d ? 1 : 0);
            grant_cyc_q.push_back(cyc);
            inflight = 1;
            idx = int'(lat_addr[7:2]);
            for (int b = 0; b < 4; b++) begin
                if (lat_we[b]) mem_words[idx][8*b +: 8] = lat_wdata[8*b +: 8];
            end
            rsp_word = mem_words[idx];
            exp_q.push_back(rsp_word);
            pending  = 1;
            wait_cnt = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
            if (scramble_en) begin
                if (want_d) begin
                    bus.d_addr = $urandom; bus.d_wdata = $urandom; bus.d_we = 4'($urandom);
                end else begin
                    bus.if_addr = $urandom;
                end
            end
        end

        total++;
        if (dbg_starve_cnt !== 4'(data_run)) begin
            bad++;
            $display("FAIL starve_cnt cyc=%0d got=%0d exp=%0d", cyc, dbg_starve_cnt, data_run);
        end
    endtask

    task automatic drain();
        int n = 0;
        keep_if = 0; keep_d = 0;
        while ((inflight || bus.if_req || bus.d_req) && n < 60) begin
            cycle();
            n++;
        end
        total++;
        if (inflight || bus.if_req || bus.d_req || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL drain cyc=%0d inflight=%0b busy=%b required idle", cyc, inflight, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        total++;
        if (bus.busy !== 1'b0 || bus.mem_en !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle busy=%b en=%b exp 0 0", bus.busy, bus.mem_en);
        end
    endtask

    task automatic test_single_fetch();
        int n0, en_cnt;
        logic [3:0] en_we;
        mem_lat = 0; en_cnt = 0; en_we = 4'hx; if_ack_cyc = -1;
        mem_words[16] = 32'h2108_0001;
        raise_if(32'h0000_0040);
        n0 = cyc;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (bus.mem_en === 1'b1) begin en_cnt++; en_we = bus.mem_we; end
        end
        total++;
        if (if_ack_cyc - n0 != 3) begin
            bad++;
            $display("FAIL fetch_latency got=%0d exp=3", if_ack_cyc - n0);
        end
        total++;
        if (bus.if_rdata !== 32'h2108_0001) begin
            bad++;
            $display("FAIL fetch_rdata got=%h exp=21080001", bus.if_rdata);
        end
        total++;
        if (en_cnt != 1 || en_we !== 4'b0000) begin
            bad++;
            $display("FAIL fetch_strobe en_cycles=%0d we=%h exp 1 0000", en_cnt, en_we);
        end
    endtask

    task automatic test_store_wait();
        int n0, if_acks0;
        logic [31:0] exp_word;
        mem_lat = 3; d_ack_cyc = -1; if_acks0 = if_ack_cnt;
        exp_word = {mem_words[0][31:16], 16'hBEEF};
        raise_d(4'b0011, 32'h0000_0100, 32'hDEAD_BEEF);
        n0 = cyc;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (bus.busy === 1'b1 && bus.mem_en === 1'b0) begin
                total++;
                if (bus.mem_we !== 4'b0011 || bus.mem_addr !== 32'h0000_0100) begin
                    bad++;
                    $display("FAIL store_hold cyc=%0d we=%h addr=%h exp 0011 00000100", cyc, bus.mem_we, bus.mem_addr);
                end
            end
            if (bus.d_ack === 1'b1) begin
                total++;
                if (bus.d_rdata !== exp_word) begin
                    bad++;
                    $display("FAIL store_rdata got=%h exp=%h", bus.d_rdata, exp_word);
                end
            end
        end
        total++;
        if (d_ack_cyc - n0 != 6) begin
            bad++;
            $display("FAIL store_latency got=%0d exp=6", d_ack_cyc - n0);
        end
        total++;
        if (if_ack_cnt != if_acks0) begin
            bad++;
            $display("FAIL store_if_ack got=%0d extra acks exp=0", if_ack_cnt - if_acks0);
        end
    endtask

    task automatic test_conflict();
        mem_lat = 0; d_ack_cyc = -1;
        grant_q.delete(); grant_cyc_q.delete();
        raise_if(32'h0000_0080);
        raise_d(4'h0, 32'h0000_00C4, 32'h0);
        for (int i = 0; i < 12; i++) cycle();
        total++;
        if (grant_q.size() != 2 || grant_q[0] != 1 || grant_q[1] != 0) begin
            bad++;
            $display("FAIL conflict_order grants=%0d first=%0d second=%0d exp 2 1 0",
                     grant_q.size(), grant_q.size() > 0 ? grant_q[0] : -1, grant_q.size() > 1 ? grant_q[1] : -1);
        end
        total++;
        if (grant_cyc_q.size() < 2 || grant_cyc_q[1] != d_ack_cyc + 1) begin
            bad++;
            $display("FAIL conflict_issue fetch_issue_cyc=%0d exp=%0d",
                     grant_cyc_q.size() > 1 ? grant_cyc_q[1] : -1, d_ack_cyc + 1);
        end
    endtask

    task automatic test_starvation();
        int cnt_after_fetch = -1;
        bit ok;
        mem_lat = 0; keep_d = 1; keep_if = 0;
        grant_q.delete(); grant_cyc_q.delete();
        raise_if(32'h0000_0010);
        raise_d_rand();
        for (int i = 0; i < 60 && grant_q.size() < 6; i++) begin
            cycle();
            if (grant_q.size() == 5 && cnt_after_fetch < 0) cnt_after_fetch = int'(dbg_starve_cnt);
        end
        ok = (grant_q.size() >= 6);
        for (int i = 0; i < 6 && ok; i++) if (grant_q[i] != ((i == 4) ? 0 : 1)) ok = 0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL starve_sequence grants=%0d exp pattern d d d d f d", grant_q.size());
        end
        total++;
        if (cnt_after_fetch != 0) begin
            bad++;
            $display("FAIL starve_clear got=%0d exp=0", cnt_after_fetch);
        end
        drain();
    endtask

    task automatic test_spurious_ready();
        int acks0;
        acks0 = if_ack_cnt + d_ack_cnt;
        spurious_en = 1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            total++;
            if (bus.busy !== 1'b0 || bus.if_ack !== 1'b0 || bus.d_ack !== 1'b0) begin
                bad++;
                $display("FAIL spurious_idle cyc=%0d busy=%b acks=%b%b exp 0 00", cyc, bus.busy, bus.if_ack, bus.d_ack);
            end
        end
        spurious_en = 0;
        total++;
        if (if_ack_cnt + d_ack_cnt != acks0) begin
            bad++;
            $display("FAIL spurious_acks got=%0d exp=0", if_ack_cnt + d_ack_cnt - acks0);
        end
    endtask

    task automatic test_random();
        int if0, d0;
        if0 = if_ack_cnt; d0 = d_ack_cnt;
        spurious_en = 1; rand_lat = 1; scramble_en = 1;
        for (int i = 0; i < 800; i++) begin
            keep_if = ($urandom_range(0, 3) == 0);
            keep_d  = ($urandom_range(0, 1) == 1);
            cycle();
            if (!bus.if_req && $urandom_range(0, 2) == 0) raise_if(rand_addr());
            if (!bus.d_req && $urandom_range(0, 1) == 0) raise_d_rand();
        end
        spurious_en = 0; scramble_en = 0; rand_lat = 0;
        drain();
        total++;
        if (if_ack_cnt - if0 < 10 || d_ack_cnt - d0 < 10) begin
            bad++;
            $display("FAIL random_progress if_acks=%0d d_acks=%0d exp each >= 10", if_ack_cnt - if0, d_ack_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_access();
        int acks0;
        mem_lat = 20;
        raise_d(4'h0, 32'h0000_0020, 32'h0);
        for (int i = 0; i < 3; i++) cycle();
        total++;
        if (bus.busy !== 1'b1 || bus.mem_en !== 1'b0) begin
            bad++;
            $display("FAIL mid_wait busy=%b en=%b exp 1 0", bus.busy, bus.mem_en);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.d_req = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.mem_we !== 4'b0000 || bus.d_ack !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset busy=%b we=%h d_ack=%b exp 0 0000 0", bus.busy, bus.mem_we, bus.d_ack);
        end
        acks0 = d_ack_cnt;
        for (int i = 0; i < 15; i++) begin
            cycle();
            total++;
            if (bus.d_ack !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_ack cyc=%0d got=%b exp=0", cyc, bus.d_ack);
            end
        end
        mem_lat = 0;
    endtask

    initial begin
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 4'h0; bus.d_addr = '0; bus.d_wdata = 32'h0;
        bus.mem_rdata = 32'h0; bus.mem_ready = 1'b0;
        inflight = 0; pending = 0; resp_done = 0; grant_is_d = 0;
        wait_cnt = 0; data_run = 0; mem_lat = 0;
        rand_lat = 0; spurious_en = 0; scramble_en = 0; keep_if = 0; keep_d = 0;
        req_if_addr = '0; req_d_addr = '0; req_d_we = 4'h0; req_d_wdata = 32'h0;
        lat_addr = '0; lat_we = 4'h0; lat_wdata = 32'h0; rsp_word = 32'h0;
        last_if_rdata = 32'h0; last_d_rdata = 32'h0;
        if_ack_cyc = -1; d_ack_cyc = -1; if_ack_cnt = 0; d_ack_cnt = 0;
        for (int i = 0; i < 64; i++) mem_words[i] = $urandom;

        test_reset();
        test_single_fetch();
        test_store_wait();
        test_conflict();
        test_starvation();
        test_spurious_ready();
        test_random();
        test_reset_mid_access();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
